// File: rtl/datamem_hs.sv
// Byte-addressed, little-endian data memory with a valid/ready request port and
// a one-entry registered response; rejects bad size, misaligned or out-of-range accesses.
module datamem_hs #(
  parameter int MEM_BYTES  = 1024,
  parameter int DATA_BYTES = 8,
  parameter int ADDR_W     = 64
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic                    req_write,
  input  logic [ADDR_W-1:0]       address,
  input  logic [8*DATA_BYTES-1:0] write_data,
  input  logic [3:0]              xfer_size,
  input  logic                    sign_ext,
  output logic                    resp_valid,
  input  logic                    resp_ready,
  output logic [8*DATA_BYTES-1:0] read_data,
  output logic                    resp_error,
  output logic [15:0]             err_count
);

  localparam int DW     = 8 * DATA_BYTES;
  localparam int WORDS  = MEM_BYTES / DATA_BYTES;
  localparam int WORD_W = $clog2(WORDS);
  localparam int LANE_W = $clog2(DATA_BYTES);
  localparam int OFF_W  = (LANE_W > 0) ? LANE_W : 1;

  // One word per row; byte A lives in lane A mod DATA_BYTES.
  logic [DW-1:0] mem [WORDS];

  logic              resp_valid_q, resp_valid_d;
  logic              resp_error_q, resp_error_d;
  logic [DW-1:0]     rdata_q, rdata_d;
  logic [15:0]       err_cnt_q, err_cnt_d;
  logic              ready_en_q;

  logic              accept, req_err, size_bad, misaligned, out_of_range;
  logic [ADDR_W:0]   end_addr;
  logic [WORD_W-1:0] widx;
  logic [OFF_W-1:0]  off;
  logic [DW-1:0]     rword, shifted, wsh, wword, rd;
  logic [15:0]       mask16;
  logic [DATA_BYTES-1:0] be;
  logic              sbit;

  // Requests are only taken once a full clock has passed with reset released.
  assign req_ready = ready_en_q && (!resp_valid_q || resp_ready);
  assign accept    = req_valid && req_ready;

  always_comb begin
    size_bad     = (xfer_size == 4'd0)
                || ((xfer_size & (xfer_size - 4'd1)) != 4'd0)
                || (32'(xfer_size) > 32'(DATA_BYTES));
    misaligned   = (address & ADDR_W'(xfer_size - 4'd1)) != '0;
    // One extra bit so address + size cannot wrap past the top of the space.
    end_addr     = {1'b0, address} + (ADDR_W+1)'(xfer_size);
    out_of_range = end_addr > (ADDR_W+1)'(MEM_BYTES);
    req_err      = size_bad || misaligned || out_of_range;
  end

  always_comb begin
    widx    = WORD_W'(address >> LANE_W);
    off     = OFF_W'(address) & OFF_W'(DATA_BYTES - 1);
    rword   = mem[widx];
    shifted = rword >> {off, 3'b000};
    wsh     = write_data << {off, 3'b000};
    mask16  = (16'd1 << xfer_size) - 16'd1;
    be      = DATA_BYTES'(mask16) << off;
    wword   = rword;
    for (int i = 0; i < DATA_BYTES; i++) begin
      if (be[i]) wword[8*i +: 8] = wsh[8*i +: 8];
    end
    sbit = 1'b0;
    for (int i = 0; i < DATA_BYTES; i++) begin
      if (i + 1 == int'(xfer_size)) sbit = shifted[8*i+7];
    end
    rd = '0;
    for (int i = 0; i < DATA_BYTES; i++) begin
      if (i < int'(xfer_size)) rd[8*i +: 8] = shifted[8*i +: 8];
      else if (sign_ext)       rd[8*i +: 8] = {8{sbit}};
    end
  end

  always_comb begin
    resp_valid_d = resp_valid_q;
    resp_error_d = resp_error_q;
    rdata_d      = rdata_q;
    err_cnt_d    = err_cnt_q;
    if (accept) begin
      resp_valid_d = 1'b1;
      resp_error_d = req_err;
      rdata_d      = (req_err || req_write) ? '0 : rd;
      if (req_err && err_cnt_q != 16'hFFFF) err_cnt_d = err_cnt_q + 16'd1;
    end else if (resp_ready) begin
      resp_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      resp_valid_q <= 1'b0;
      resp_error_q <= 1'b0;
      rdata_q      <= '0;
      err_cnt_q    <= '0;
      ready_en_q   <= 1'b0;
    end else begin
      resp_valid_q <= resp_valid_d;
      resp_error_q <= resp_error_d;
      rdata_q      <= rdata_d;
      err_cnt_q    <= err_cnt_d;
      ready_en_q   <= 1'b1;
    end
  end

  // Storage is deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (accept && req_write && !req_err) mem[widx] <= wword;
  end

  assign resp_valid = resp_valid_q;
  assign resp_error = resp_error_q;
  assign read_data  = rdata_q;
  assign err_count  = err_cnt_q;

endmodule

// File: tb/tb_datamem_hs.sv
// Bench for datamem_hs: directed scenarios plus random traffic against a
// byte-array reference model of the memory and response register.
module tb_datamem_hs;

  logic        clk, reset_n;
  logic        req_valid, req_ready, req_write, sign_ext;
  logic [63:0] address, write_data, read_data;
  logic [3:0]  xfer_size;
  logic        resp_valid, resp_ready, resp_error;
  logic [15:0] err_count;

  datamem_hs #(.MEM_BYTES(1024), .DATA_BYTES(8), .ADDR_W(64)) dut (
    .clk(clk), .reset_n(reset_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .address(address), .write_data(write_data), .xfer_size(xfer_size),
    .sign_ext(sign_ext),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .read_data(read_data), .resp_error(resp_error), .err_count(err_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int ncomp = 0;
  int nfail = 0;

  logic [7:0]  mmem [0:1023];
  logic        m_valid;
  logic        m_err;
  logic [63:0] m_data;
  logic [15:0] m_cnt;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    ncomp++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference behaviour of one accepted request, straight from the access rules.
  function automatic void model_resp(input logic wr, input logic [63:0] a,
                                     input logic [63:0] wd, input logic [3:0] sz,
                                     input logic sx, output logic er,
                                     output logic [63:0] rd);
    int n;
    logic [64:0] sum;
    n   = int'(sz);
    sum = {1'b0, a} + 65'(n);
    rd  = '0;
    if (n == 0) er = 1'b1;
    else er = ((n & (n - 1)) != 0) || (n > 8) || ((a % 64'(n)) != 0) || (sum > 65'd1024);
    if (!er) begin
      for (int i = 0; i < n; i++) begin
        if (wr) mmem[int'(a[9:0]) + i] = wd[8*i +: 8];
        else    rd[8*i +: 8] = mmem[int'(a[9:0]) + i];
      end
      if (!wr && sx && rd[8*n-1]) begin
        for (int i = n; i < 8; i++) rd[8*i +: 8] = 8'hFF;
      end
      if (wr) rd = '0;
    end
  endfunction

  // One clock of traffic: drive, predict, clock, compare.
  task automatic cycle(input logic v, input logic wr, input logic [63:0] a,
                       input logic [63:0] wd, input logic [3:0] sz,
                       input logic sx, input logic rr);
    logic exp_ready, acc, er;
    logic [63:0] rd;
    req_valid = v; req_write = wr; address = a; write_data = wd;
    xfer_size = sz; sign_ext = sx; resp_ready = rr;
    #1;
    exp_ready = !m_valid || rr;
    chk("req_ready", 64'(req_ready), 64'(exp_ready));
    acc = v && exp_ready;
    @(posedge clk); #1;
    if (acc) begin
      model_resp(wr, a, wd, sz, sx, er, rd);
      m_valid = 1'b1;
      m_err   = er;
      m_data  = er ? 64'd0 : rd;
      if (er && m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
    end else if (rr) begin
      m_valid = 1'b0;
    end
    req_valid = 1'b0;
    chk("resp_valid", 64'(resp_valid), 64'(m_valid));
    chk("err_count", 64'(err_count), 64'(m_cnt));
    if (m_valid) begin
      chk("resp_error", 64'(resp_error), 64'(m_err));
      chk("read_data", read_data, m_data);
    end
  endtask

  initial begin
    logic [3:0]  sz;
    logic [63:0] a;
    m_valid = 1'b0; m_err = 1'b0; m_data = '0; m_cnt = '0;
    reset_n = 1'b0; req_valid = 1'b0; req_write = 1'b0; address = '0;
    write_data = '0; xfer_size = '0; sign_ext = 1'b0; resp_ready = 1'b1;
    #1;
    chk("rst_resp_valid", 64'(resp_valid), 64'd0);
    chk("rst_resp_error", 64'(resp_error), 64'd0);
    chk("rst_read_data", read_data, 64'd0);
    chk("rst_err_count", 64'(err_count), 64'd0);
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    @(posedge clk); #1;
    chk("ready_after_reset", 64'(req_ready), 64'd1);

    // Write then read back, with and without sign extension.
    cycle(1, 1, 64'h10, 64'h1122334455667788, 4'd8, 0, 1);
    chk("wr_error", 64'(resp_error), 64'd0);
    cycle(1, 0, 64'h10, 64'h0, 4'd8, 0, 1);
    chk("rd8_data", read_data, 64'h1122334455667788);
    cycle(1, 0, 64'h10, 64'h0, 4'd1, 1, 1);
    chk("rd1_sext", read_data, 64'hFFFFFFFFFFFFFF88);
    cycle(1, 0, 64'h10, 64'h0, 4'd1, 0, 1);
    chk("rd1_zext", read_data, 64'h88);

    // Misaligned write is rejected and leaves memory untouched.
    cycle(1, 1, 64'h12, 64'hDEADBEEFCAFEF00D, 4'd4, 0, 1);
    chk("misalign_err", 64'(resp_error), 64'd1);
    chk("misalign_cnt", 64'(err_count), 64'd1);
    cycle(1, 0, 64'h10, 64'h0, 4'd8, 0, 1);
    chk("misalign_keep", read_data, 64'h1122334455667788);

    // Out of range and wrapping addresses.
    cycle(1, 0, 64'd1020, 64'h0, 4'd8, 0, 1);
    chk("oob_err", 64'(resp_error), 64'd1);
    cycle(1, 0, 64'hFFFFFFFFFFFFFFF8, 64'h0, 4'd8, 0, 1);
    chk("wrap_err", 64'(resp_error), 64'd1);
    cycle(1, 0, 64'h10, 64'h0, 4'd3, 0, 1);
    cycle(1, 0, 64'h10, 64'h0, 4'd0, 0, 1);

    // Back-to-back write then read of the same bytes, then a signed halfword.
    cycle(1, 1, 64'h20, 64'h00000000A5B6C7D8, 4'd4, 0, 1);
    cycle(1, 0, 64'h20, 64'h0, 4'd4, 0, 1);
    chk("raw_data", read_data, 64'hA5B6C7D8);
    cycle(1, 0, 64'h22, 64'h0, 4'd2, 1, 1);
    chk("sext16", read_data, 64'hFFFFFFFFFFFFA5B6);

    // Backpressure: first response held for three cycles, second taken on pop.
    cycle(1, 0, 64'h10, 64'h0, 4'd4, 0, 1);
    for (int k = 0; k < 3; k++) begin
      cycle(1, 0, 64'h20, 64'h0, 4'd4, 0, 0);
      chk("bp_hold", read_data, 64'h55667788);
    end
    cycle(1, 0, 64'h20, 64'h0, 4'd4, 0, 1);
    chk("bp_second", read_data, 64'hA5B6C7D8);
    cycle(0, 0, 64'h0, 64'h0, 4'd0, 0, 1);

    // Reset while a response is pending, with a write presented across release.
    cycle(1, 0, 64'h10, 64'h0, 4'd8, 0, 0);
    #2 reset_n = 1'b0;
    #1;
    chk("midrst_valid", 64'(resp_valid), 64'd0);
    chk("midrst_cnt", 64'(err_count), 64'd0);
    req_valid = 1'b1; req_write = 1'b1; address = 64'h10;
    write_data = 64'hDEADBEEFDEADBEEF; xfer_size = 4'd8; resp_ready = 1'b1;
    @(posedge clk);
    reset_n = 1'b1;
    #1 req_valid = 1'b0;
    m_valid = 1'b0; m_cnt = '0;
    chk("release_valid", 64'(resp_valid), 64'd0);
    @(posedge clk); #1;
    chk("post_rst_valid", 64'(resp_valid), 64'd0);
    cycle(1, 0, 64'h10, 64'h0, 4'd8, 0, 1);
    chk("no_write_on_release", read_data, 64'h1122334455667788);

    // Fill memory so every random read has a defined expectation.
    for (int k = 0; k < 128; k++)
      cycle(1, 1, 64'(k * 8), {$urandom, $urandom}, 4'd8, 0, 1);

    for (int k = 0; k < 500; k++) begin
      if ($urandom_range(0, 5) == 0) sz = 4'($urandom);
      else sz = 4'd1 << $urandom_range(0, 3);
      if ($urandom_range(0, 7) == 0) a = {$urandom, $urandom};
      else if ($urandom_range(0, 7) == 0) a = 64'($urandom_range(0, 1023));
      else a = 64'($urandom_range(0, 1023)) & ~64'((sz == 0) ? 4'd0 : sz - 4'd1);
      cycle($urandom_range(0, 3) != 0, 1'($urandom), a, {$urandom, $urandom}, sz,
            1'($urandom), $urandom_range(0, 3) != 0);
    end
    cycle(0, 0, 64'h0, 64'h0, 4'd0, 0, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncomp, nfail);
    $finish;
  end

endmodule

// File: doc/datamem_hs.md
DATAMEM_HS -- requirements
Module: datamem_hs

Interface
REQ-001 Parameter MEM_BYTES, default 1024: memory capacity in bytes; SHALL be a power of two greater than DATA_BYTES.
REQ-002 Parameter DATA_BYTES, default 8: data-path width in bytes; SHALL be a power of two, 1..8.
REQ-003 Parameter ADDR_W, default 64: address width in bits.
REQ-004 Ports (clock and reset first):
- clk  in  1  sole clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  block accepts the request this cycle.
- req_write  in  1  1 = write, 0 = read.
- address  in  ADDR_W  byte address.
- write_data  in  8*DATA_BYTES  little-endian store data.
- xfer_size  in  4  bytes to transfer.
- sign_ext  in  1  for reads, sign-extend from the top loaded byte.
- resp_valid  out  1  response present.
- resp_ready  in  1  consumer takes the response.
- read_data  out  8*DATA_BYTES  load result; 0 for writes and errors.
- resp_error  out  1  request was rejected.
- err_count  out  16  count of rejected requests; saturates at 16'hFFFF.

Function
REQ-005 The block SHALL accept a request on a rising clk edge where req_valid && req_ready; req_ready SHALL equal !resp_valid || resp_ready.
REQ-006 The block SHALL hold exactly one response in a one-entry output register. resp_valid, read_data and resp_error SHALL be stable while resp_valid && !resp_ready.
REQ-007 Each accepted request SHALL produce a response exactly 1 cycle later (resp_valid high on the next cycle), including writes and errors.
REQ-008 The block SHALL reject a request with resp_error=1, read_data=0, no memory change and err_count+1 when any of these holds:
- xfer_size is 0, not a power of two, or greater than DATA_BYTES;
- address is not a multiple of xfer_size;
- address + xfer_size > MEM_BYTES, with the sum computed without overflow.
REQ-009 A valid write SHALL update bytes address..address+xfer_size-1 at the accept edge, taking the data from write_data[8*i+7:8*i]. Bytes above xfer_size SHALL be ignored.
REQ-010 A valid read SHALL place byte address+i into read_data[8*i+7:8*i] for i < xfer_size. Upper bytes SHALL be zero, or copies of bit 8*xfer_size-1 when sign_ext=1.
REQ-011 Memory is byte-addressed and little-endian. Byte address A SHALL map to lane A mod DATA_BYTES.
REQ-012 A read accepted the cycle after a write to the same bytes SHALL return the new data, with no stall.
REQ-013 A simultaneous response pop and new accept SHALL replace the response register with no bubble cycle.
REQ-014 Memory contents SHALL be uninitialised (X in simulation) and are not cleared by reset.
REQ-015 Read data SHALL come from a registered read; no combinational path SHALL exist from address to read_data.

Reset
REQ-016 While reset_n=0 the following SHALL hold immediately, asynchronously:
- resp_valid=0, resp_error=0, read_data=0, err_count=0;
- req_ready=1 one cycle after reset_n rises.
REQ-017 A request in flight when reset asserts SHALL be dropped, and no response SHALL appear afterwards.
REQ-018 A write accepted on the same edge that reset deasserts SHALL NOT be performed; accept SHALL require reset_n=1 before the edge.

Verification
REQ-019 Write then read (MEM_BYTES=1024, DATA_BYTES=8) -> read_data = 64'h1122334455667788, resp_error=0.
- Stimulus: write addr 0x10, size 8, data 64'h1122334455667788; then read the same.
REQ-020 Sign extension (after REQ-019) -> read_data = 64'hFFFFFFFFFFFFFF88 with sign_ext=1, 64'h88 with sign_ext=0.
- Stimulus: read addr 0x10, size 1.
REQ-021 Misaligned write -> resp_error=1, err_count=1, memory at 0x10..0x17 unchanged on readback.
- Stimulus: write addr 0x12, size 4.
REQ-022 Out-of-bounds read -> resp_error=1. Address wrap -> also rejected.
- Stimulus: read addr 1020, size 8; read addr 2^64-8, size 8.
REQ-023 Backpressure -> first response held stable; second accepted only on the pop cycle; two responses in order; no loss.
- Stimulus: resp_ready=0 for 3 cycles with two reads queued.
REQ-024 Reset mid-operation -> resp_valid=0 immediately; no response after release.
- Stimulus: assert reset_n=0 while resp_valid=1.
